// File: rtl/lexpander_pkg.sv
// Shared code-format constants and the decoded-code payload of the 8-bit log codec.
package lexpander_pkg;

    localparam int unsigned CODE_WIDTH  = 8;
    localparam int unsigned SIGN_BIT    = 7;
    localparam int unsigned EXP_MSB     = 6;
    localparam int unsigned EXP_LSB     = 4;
    localparam int unsigned MANT_MSB    = 3;
    localparam int unsigned MANT_LSB    = 0;
    localparam int unsigned EXP_WIDTH   = EXP_MSB - EXP_LSB + 1;
    localparam int unsigned MANT_WIDTH  = MANT_MSB - MANT_LSB + 1;
    localparam int unsigned MAG_WIDTH   = 13;
    localparam int unsigned SCALE_SHIFT = 3;
    localparam int unsigned LIN_MAX     = 32256;

    // Decoded code: sign plus unscaled linear magnitude
    typedef struct packed {
        logic                 sign;
        logic [MAG_WIDTH-1:0] mag;
    } dec_t;

endpackage

// File: rtl/lexpander_decode.sv
// Combinational map from an 8-bit sign/exponent/mantissa code to {sign, magnitude}.
module lexpander_decode
    import lexpander_pkg::*;
(
    input  logic [CODE_WIDTH-1:0] i_code,
    output dec_t                  o_dec_c
);

    logic [EXP_WIDTH-1:0]  w_exp;
    logic [MANT_WIDTH-1:0] w_mant;
    logic [MAG_WIDTH-1:0]  w_base;

    assign w_exp  = i_code[EXP_MSB:EXP_LSB];
    assign w_mant = i_code[MANT_MSB:MANT_LSB];
    // Normalised segments carry an implicit leading one above the mantissa
    assign w_base = MAG_WIDTH'({1'b1, w_mant, 1'b1});

    // Segment 0 is linear; higher segments double in step size per exponent
    always_comb begin
        o_dec_c.sign = i_code[SIGN_BIT];
        o_dec_c.mag  = MAG_WIDTH'({w_mant, 1'b1});
        if (w_exp != '0) begin
            o_dec_c.mag = w_base << (w_exp - EXP_WIDTH'(1));
        end
    end

endmodule

// File: rtl/lexpander.sv
// Two-stage pipelined log expander with valid/ready backpressure.
module lexpander
    import lexpander_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CODE_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_data
);

    logic                 w_ce;
    logic                 w_accept;
    dec_t                 w_dec;
    logic [OUT_WIDTH-1:0] w_lin;
    logic [OUT_WIDTH-1:0] w_signed;

    logic                 r_s1_valid;
    dec_t                 r_s1;
    logic                 r_o_valid;
    logic [OUT_WIDTH-1:0] r_o_data;

    // Whole pipeline advances together unless a valid output is being held
    assign w_ce     = !r_o_valid || i_ready;
    assign o_ready  = w_ce;
    assign w_accept = i_valid && w_ce;

    lexpander_decode u_decode (
        .i_code  (i_data),
        .o_dec_c (w_dec)
    );

    // Scale to the linear PCM grid and apply sign; |lin| <= LIN_MAX so negation is safe
    assign w_lin    = OUT_WIDTH'(r_s1.mag) << SCALE_SHIFT;
    assign w_signed = r_s1.sign ? (-w_lin) : w_lin;

    // Stage 1: capture the decoded code and its valid bit
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_ce) begin
            r_s1_valid <= w_accept;
            r_s1       <= w_dec;
        end
    end

    // Stage 2: capture the signed, scaled sample driven on o_data
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
        end else if (w_ce) begin
            r_o_valid <= r_s1_valid;
            r_o_data  <= w_signed;
        end
    end

    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;

endmodule

// File: tb/tb_lexpander.sv
// Directed and randomised self-checking bench for lexpander.
module tb_lexpander;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_data;

    int          n_checks;
    int          n_errors;
    logic [15:0] q[$];
    logic [15:0] obs_log[$];
    int          emits;
    int          cyc;
    int          first_emit;
    int          last_emit;
    bit          prev_stall;
    logic [15:0] prev_data;

    lexpander #(.OUT_WIDTH(16)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: segment 0 is (2M+1), segment E>0 is (33+2M)<<(E-1); then x8 and sign
    function automatic logic [15:0] model(input logic [7:0] c);
        int e;
        int m;
        int mag;
        int lin;
        e = int'(c[6:4]);
        m = int'(c[3:0]);
        if (e == 0) mag = 2 * m + 1;
        else        mag = (33 + 2 * m) << (e - 1);
        lin = mag * 8;
        if (c[7]) return 16'(-lin);
        return 16'(lin);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, score the edge's transfers, advance to next negedge
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, output logic acc);
        logic emt;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        #1;
        if (prev_stall) begin
            check("hold_valid", 32'(o_valid), 32'(1));
            check("hold_data", 32'(o_data), 32'(prev_data));
        end
        check("ready", 32'(o_ready), 32'(!o_valid || r));
        acc = v && o_ready;
        emt = o_valid && r;
        if (emt) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'(q.size()), 32'(1));
            end else begin
                check("data", 32'(o_data), 32'(q.pop_front()));
            end
            obs_log.push_back(o_data);
            emits++;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
        end
        if (acc) q.push_back(model(d));
        prev_stall = o_valid && !r;
        prev_data  = o_data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Single code at full rate: output valid two cycles after the accept cycle
    task automatic single(input logic [7:0] code, input logic [15:0] exp);
        logic a;
        cycle(1'b1, code, 1'b1, a);
        check("single_acc", 32'(a), 32'(1));
        check("lat_early", 32'(o_valid), 32'(0));
        cycle(1'b0, 8'h00, 1'b1, a);
        check("lat_valid", 32'(o_valid), 32'(1));
        check("lat_data", 32'(o_data), 32'(exp));
        cycle(1'b0, 8'h00, 1'b1, a);
        check("lat_after", 32'(o_valid), 32'(0));
    endtask

    initial begin
        logic a;
        int   sent;
        int   guard;
        int   bad;
        n_checks   = 0;
        n_errors   = 0;
        emits      = 0;
        cyc        = 0;
        first_emit = -1;
        last_emit  = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_data     = 8'h00;
        i_ready    = 1'b0;

        // Reset state: o_ready high even with i_ready low
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_data", 32'(o_data), 32'(0));
        check("rst_ready", 32'(o_ready), 32'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed single codes
        single(8'h00, 16'h0008);
        single(8'h0F, 16'h00F8);
        single(8'h10, 16'h0108);
        single(8'h7F, 16'h7E00);
        single(8'h80, 16'hFFF8);
        single(8'hFF, 16'h8200);

        // Exhaustive sweep at full rate
        q.delete();
        obs_log.delete();
        emits      = 0;
        first_emit = -1;
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b1, a);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, a);
        check("sweep_count", 32'(emits), 32'(256));
        check("sweep_span", 32'(last_emit - first_emit + 1), 32'(256));
        check("sweep_drain", 32'(q.size()), 32'(0));
        bad = 0;
        if (obs_log.size() >= 128) begin
            for (int i = 1; i < 128; i++) begin
                if ($signed(obs_log[i]) <= $signed(obs_log[i-1])) bad++;
            end
        end
        check("sweep_mono", 32'(bad), 32'(0));

        // Backpressure: stall three cycles once the first sample is valid
        q.delete();
        emits = 0;
        cycle(1'b1, 8'h10, 1'b1, a);
        cycle(1'b1, 8'h20, 1'b1, a);
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = 8'h30;
            i_ready = 1'b0;
            #1;
            check("stall_valid", 32'(o_valid), 32'(1));
            check("stall_data", 32'(o_data), 32'(16'h0108));
            check("stall_ready", 32'(o_ready), 32'(0));
            cycle(1'b1, 8'h30, 1'b0, a);
        end
        cycle(1'b1, 8'h30, 1'b1, a);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, a);
        check("bp_count", 32'(emits), 32'(3));
        check("bp_drain", 32'(q.size()), 32'(0));

        // Random valid/ready over 10k accepted codes
        q.delete();
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 80000) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), a);
            if (a) sent++;
            guard++;
        end
        check("rand_budget", 32'(guard < 80000), 32'(1));
        for (int k = 0; k < 20 && q.size() != 0; k++) cycle(1'b0, 8'h00, 1'b1, a);
        check("rand_drain", 32'(q.size()), 32'(0));

        // Reset with two samples in flight
        q.delete();
        prev_stall = 1'b0;
        cycle(1'b1, 8'h10, 1'b1, a);
        cycle(1'b1, 8'h20, 1'b1, a);
        i_valid = 1'b0;
        i_ready = 1'b1;
        #1;
        check("pre_rst_valid", 32'(o_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'(0));
        check("mid_rst_data", 32'(o_data), 32'(0));
        check("mid_rst_ready", 32'(o_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        prev_stall = 1'b0;
        cycle(1'b0, 8'h00, 1'b1, a);
        check("post_rst_empty", 32'(o_valid), 32'(0));
        single(8'h30, 16'h0420);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
